game_outcome_tracker: RTL and testbench

Per-game round state machine that turns raw gameplay event pulses (start, hit, miss, pause toggle) into the 2-bit game outcome code consumed by the LED status stage. It counts hits and misses, runs a round timeout, and holds the final win/lose result until the next start. One instance per game; the two instances drive `game1_state` and `game2_state` of the LED status block.

---
 rtl/game_outcome_tracker_pkg.sv | 28 ++
 rtl/game_outcome_tracker_if.sv | 29 ++
 rtl/game_outcome_tracker_round_timer.sv | 30 +++
 rtl/game_outcome_tracker.sv | 103 ++++++++++
 tb/tb_game_outcome_tracker.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/game_outcome_tracker_pkg.sv
// Encodings shared by the round tracker and the LED status stage that
// consumes its outcome code.
package game_pkg;

  typedef enum logic [1:0] {
    GS_PAUSED = 2'b00,
    GS_WIN    = 2'b01,
    GS_LOSE   = 2'b10
  } game_state_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    PAUSED = 3'd2,
    WIN    = 3'd3,
    LOSE   = 3'd4
  } round_fsm_t;

  // IDLE, PLAY and PAUSED all report the neutral code.
  function automatic game_state_t outcome_code(input logic [2:0] st);
    case (st)
      WIN:     return GS_WIN;
      LOSE:    return GS_LOSE;
      default: return GS_PAUSED;
    endcase
  endfunction

endpackage

// File: rtl/game_outcome_tracker_if.sv
// Gameplay event pulses in, round outcome and counters out.
interface game_outcome_tracker_if #(
  parameter int WIN_HITS   = 8,
  parameter int MAX_MISSES = 3
);

  localparam int HW = $clog2(WIN_HITS + 1);
  localparam int MW = $clog2(MAX_MISSES + 1);

  logic                     start;
  logic                     pause_toggle;
  logic                     hit;
  logic                     miss;
  game_pkg::game_state_t    game_state;
  logic [HW-1:0]            hits;
  logic [MW-1:0]            misses;
  logic                     playing;

  modport master (
    output start, pause_toggle, hit, miss,
    input  game_state, hits, misses, playing
  );

  modport slave (
    input  start, pause_toggle, hit, miss,
    output game_state, hits, misses, playing
  );

endinterface

// File: rtl/game_outcome_tracker_round_timer.sv
// Counts active-play cycles and flags the cycle on which the round times out.
module round_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Holds at LAST rather than wrapping; the FSM leaves PLAY on expiry anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/game_outcome_tracker.sv
// Per-game round FSM: turns start/hit/miss/pause pulses into the 2-bit
// outcome code, with hit/miss counters and an active-play timeout.
module game_outcome_tracker
  import game_pkg::*;
#(
  parameter int WIN_HITS       = 8,
  parameter int MAX_MISSES     = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  game_outcome_tracker_if.slave  bus
);

  localparam int HW = $clog2(WIN_HITS + 1);
  localparam int MW = $clog2(MAX_MISSES + 1);
  localparam logic [HW-1:0] HITS_MAX   = HW'(WIN_HITS);
  localparam logic [MW-1:0] MISSES_MAX = MW'(MAX_MISSES);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_PLAY   = PLAY;
  localparam logic [2:0] ST_PAUSED = PAUSED;
  localparam logic [2:0] ST_WIN    = WIN;
  localparam logic [2:0] ST_LOSE   = LOSE;

  logic [2:0]    state_q, state_d;
  logic [HW-1:0] hits_q, hits_d, hits_inc;
  logic [MW-1:0] misses_q, misses_d, misses_inc;
  game_state_t   game_state_q;
  logic          playing_q;
  logic          expire;

  round_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_round_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.start),
    .enable ((state_q == ST_PLAY) && !bus.start),
    .expire (expire)
  );

  always_comb begin
    state_d    = state_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    hits_inc   = (bus.hit  && hits_q   != HITS_MAX)   ? hits_q + 1'b1   : hits_q;
    misses_inc = (bus.miss && misses_q != MISSES_MAX) ? misses_q + 1'b1 : misses_q;

    if (bus.start) begin
      state_d  = ST_PLAY;
      hits_d   = '0;
      misses_d = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          hits_d = hits_inc;
          // A winning hit freezes the miss count: the simultaneous miss is dropped.
          if (hits_inc == HITS_MAX) begin
            state_d = ST_WIN;
          end else begin
            misses_d = misses_inc;
            if (misses_inc == MISSES_MAX || expire) begin
              state_d = ST_LOSE;
            end else if (bus.pause_toggle) begin
              state_d = ST_PAUSED;
            end
          end
        end
        ST_PAUSED: begin
          if (bus.pause_toggle) begin
            state_d = ST_PLAY;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hits_q       <= '0;
      misses_q     <= '0;
      game_state_q <= GS_PAUSED;
      playing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      game_state_q <= outcome_code(state_d);
      playing_q    <= (state_d == ST_PLAY);
    end
  end

  assign bus.game_state = game_state_q;
  assign bus.hits       = hits_q;
  assign bus.misses     = misses_q;
  assign bus.playing    = playing_q;

endmodule

// File: tb/tb_game_outcome_tracker.sv
// Directed round scenarios plus randomized pulses, scored against a
// round-level reference model.
module tb_game_outcome_tracker;

  localparam int WIN_HITS       = 3;
  localparam int MAX_MISSES     = 2;
  localparam int TIMEOUT_CYCLES = 20;

  typedef enum {M_IDLE, M_PLAY, M_PAUSED, M_WON, M_LOST} mode_t;

  logic clk = 1'b0;
  logic rst;

  game_outcome_tracker_if #(.WIN_HITS(WIN_HITS), .MAX_MISSES(MAX_MISSES)) bus ();

  game_outcome_tracker #(
    .WIN_HITS       (WIN_HITS),
    .MAX_MISSES     (MAX_MISSES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  mode_t mode;
  int    exp_hits;
  int    exp_misses;
  int    active_cycles;
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int expCode();
    if (mode == M_WON)  return 1;
    if (mode == M_LOST) return 2;
    return 0;
  endfunction

  task automatic modelReset();
    mode          = M_IDLE;
    exp_hits      = 0;
    exp_misses    = 0;
    active_cycles = 0;
  endtask

  // One clock edge of the round rules, in priority order.
  task automatic modelStep(input bit s, input bit p, input bit h, input bit m);
    int  nh, nm;
    bit  timed_out;
    if (s) begin
      mode          = M_PLAY;
      exp_hits      = 0;
      exp_misses    = 0;
      active_cycles = 0;
    end else if (mode == M_PLAY) begin
      nh = (exp_hits + int'(h) > WIN_HITS) ? WIN_HITS : exp_hits + int'(h);
      nm = (exp_misses + int'(m) > MAX_MISSES) ? MAX_MISSES : exp_misses + int'(m);
      active_cycles++;
      timed_out = (active_cycles >= TIMEOUT_CYCLES);
      exp_hits  = nh;
      if (nh == WIN_HITS) begin
        mode = M_WON;
      end else begin
        exp_misses = nm;
        if (nm == MAX_MISSES || timed_out) mode = M_LOST;
        else if (p)                        mode = M_PAUSED;
      end
    end else if (mode == M_PAUSED) begin
      if (p) mode = M_PLAY;
    end
  endtask

  task automatic checkAll();
    checkOutput("game_state", bus.game_state, expCode());
    checkOutput("hits",       bus.hits,       exp_hits);
    checkOutput("misses",     bus.misses,     exp_misses);
    checkOutput("playing",    bus.playing,    (mode == M_PLAY) ? 1 : 0);
  endtask

  task automatic applyStimulus(input bit s, input bit p, input bit h, input bit m);
    @(negedge clk);
    bus.start        = s;
    bus.pause_toggle = p;
    bus.hit          = h;
    bus.miss         = m;
    @(posedge clk);
    modelStep(s, p, h, m);
    #1;
    checkAll();
  endtask

  // Reset asserted and released between two rising edges.
  task automatic pulseReset();
    @(negedge clk);
    bus.start        = 1'b0;
    bus.pause_toggle = 1'b0;
    bus.hit          = 1'b0;
    bus.miss         = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_game_state", bus.game_state, 0);
    checkOutput("rst_hits",       bus.hits,       0);
    checkOutput("rst_misses",     bus.misses,     0);
    checkOutput("rst_playing",    bus.playing,    0);
    #1 rst = 1'b0;
  endtask

  int hit_div[4]   = '{3, 12, 2, 20};
  int miss_div[4]  = '{5, 15, 2, 30};
  int pause_div[4] = '{10, 6, 4, 20};

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.pause_toggle = 1'b0;
    bus.hit          = 1'b0;
    bus.miss         = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    rst = 1'b0;

    // Win after three spaced hits; extra hits saturate.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < WIN_HITS; i++) begin
      applyStimulus(0, 0, 1, 0);
      if (i == WIN_HITS - 1) begin
        checkOutput("win_code",    bus.game_state, 1);
        checkOutput("win_hits",    bus.hits,       3);
        checkOutput("win_playing", bus.playing,    0);
      end
      applyStimulus(0, 0, 0, 0);
    end
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("win_hits_hold", bus.hits, 3);

    // Lose on misses with a hit in the same cycle.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("lose_code",   bus.game_state, 2);
    checkOutput("lose_hits",   bus.hits,       1);
    checkOutput("lose_misses", bus.misses,     2);

    // Winning hit beats a simultaneous losing miss.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("wbl_code",   bus.game_state, 1);
    checkOutput("wbl_misses", bus.misses,     1);

    // Timeout stretched by ten paused cycles; hits while paused are ignored.
    applyStimulus(1, 0, 0, 0);
    for (int e = 1; e <= 30; e++) begin
      applyStimulus(0, (e == 5 || e == 15), (e == 8 || e == 10), 0);
      if (e == 29) checkOutput("timeout_early", bus.game_state, 0);
    end
    checkOutput("timeout_code", bus.game_state, 2);
    checkOutput("timeout_hits", bus.hits,       0);

    // Start wins over a same-cycle hit when restarting from LOSE.
    applyStimulus(1, 0, 1, 0);
    checkOutput("restart_code",    bus.game_state, 0);
    checkOutput("restart_hits",    bus.hits,       0);
    checkOutput("restart_playing", bus.playing,    1);

    // Asynchronous reset mid-round, then pause in IDLE does nothing.
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    pulseReset();
    applyStimulus(0, 1, 0, 0);
    checkOutput("idle_pause_playing", bus.playing, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_rst_start", bus.playing, 1);

    // Randomized phases with varying event density.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 150; c++) begin
        bit s, p, h, m;
        if (mode == M_IDLE || mode == M_WON || mode == M_LOST)
          s = ($urandom_range(0, 5) == 0);
        else
          s = ($urandom_range(0, 59) == 0);
        p = ($urandom_range(0, pause_div[ph] - 1) == 0);
        h = ($urandom_range(0, hit_div[ph] - 1) == 0);
        m = ($urandom_range(0, miss_div[ph] - 1) == 0);
        applyStimulus(s, p, h, m);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
